// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared defaults and state/op types for the memory port arbiter
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, CORE, PANEL} arb_state_e;
  typedef enum logic [1:0] {OP_NONE, OP_LOAD, OP_LOOK} panel_op_e;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - registered rising-edge detector for one front-panel button
module btn_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  logic btn_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) btn_q <= 1'b0;
    else         btn_q <= btn_i;
  end

  assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - registered-grant arbiter sharing main memory between core and panel
// Optional build macro PANEL_AUTOINC_EN adds the auto-incrementing panel address and panel_addr_o.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
`ifdef PANEL_AUTOINC_EN
  output logic [ADDR_W-1:0] panel_addr_o,
`endif
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              panel_en_i,
  input  logic              btn_load_i,
  input  logic              btn_look_i,
  input  logic [ADDR_W-1:0] sw_addr_i,
  input  logic [DATA_W-1:0] sw_data_i,
  input  logic              core_val_i,
  input  logic              core_wen_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_rdy_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              mem_val_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_rdy_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_upd_o,
  output logic              panel_busy_o
);

  arb_state_e        state_q, state_d;
  panel_op_e         op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] cap_addr;
  logic              load_rise, look_rise;
  logic              detect, panel_done;

  btn_edge u_load_edge (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_load_i), .rise_o(load_rise));
  btn_edge u_look_edge (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_look_i), .rise_o(look_rise));

  // Edges only register while nothing is pending; op_q stays set until completion.
  assign detect     = (op_q == OP_NONE) && (load_rise || look_rise);
  assign panel_done = (state_q == PANEL) && mem_rdy_i;

`ifdef PANEL_AUTOINC_EN
  logic [ADDR_W-1:0] pa_q, sa_q;

  // A changed switch setting overrides the running address; otherwise keep stepping.
  assign cap_addr     = (sw_addr_i != sa_q) ? sw_addr_i : pa_q;
  assign panel_addr_o = pa_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pa_q <= '0;
      sa_q <= '0;
    end else begin
      if (detect && (sw_addr_i != sa_q)) sa_q <= sw_addr_i;
      if (panel_done)                    pa_q <= addr_q + ADDR_W'(1);
    end
  end
`else
  assign cap_addr = sw_addr_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q   <= OP_NONE;
      addr_q <= '0;
      data_q <= '0;
    end else if (detect) begin
      op_q   <= load_rise ? OP_LOAD : OP_LOOK;
      addr_q <= cap_addr;
      data_q <= sw_data_i;
    end else if (panel_done) begin
      op_q <= OP_NONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      disp_data_o <= '0;
      disp_upd_o  <= 1'b0;
    end else begin
      disp_upd_o <= panel_done;
      if (panel_done) disp_data_o <= (op_q == OP_LOOK) ? mem_rdata_i : data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_val_o   = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    core_rdy_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_val_i)                          state_d = CORE;
        else if ((op_q != OP_NONE) && panel_en_i) state_d = PANEL;
      end
      CORE: begin
        // Request held high even if the core misbehaves, so the memory handshake stays legal.
        mem_val_o   = 1'b1;
        mem_wen_o   = core_wen_i;
        mem_addr_o  = core_addr_i;
        mem_wdata_o = core_wdata_i;
        core_rdy_o  = mem_rdy_i;
        if (mem_rdy_i) state_d = IDLE;
      end
      PANEL: begin
        mem_val_o   = 1'b1;
        mem_wen_o   = (op_q == OP_LOAD);
        mem_addr_o  = addr_q;
        mem_wdata_o = data_q;
        if (mem_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign core_rdata_o = mem_rdata_i;
  assign panel_busy_o = (op_q != OP_NONE);

  core_val_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == CORE) |-> core_val_i);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized directed bench for mem_port_arbiter with a memory/panel reference model
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        panel_en_i = 1'b0, btn_load_i = 1'b0, btn_look_i = 1'b0;
  logic [7:0]  sw_addr_i = '0, core_addr_i = '0, mem_addr_o;
  logic [15:0] sw_data_i = '0, core_wdata_i = '0, core_rdata_o, mem_wdata_o, mem_rdata_i = '0, disp_data_o;
  logic        core_val_i = 1'b0, core_wen_i = 1'b0, core_rdy_o;
  logic        mem_val_o, mem_wen_o, mem_rdy_i = 1'b0, disp_upd_o, panel_busy_o;
`ifdef PANEL_AUTOINC_EN
  logic [7:0]  panel_addr_o;
  logic [7:0]  m_pa = '0, m_sa = '0;
`endif

  mem_port_arbiter dut (
`ifdef PANEL_AUTOINC_EN
    .panel_addr_o(panel_addr_o),
`endif
    .clk_i(clk_i), .rst_ni(rst_ni), .panel_en_i(panel_en_i),
    .btn_load_i(btn_load_i), .btn_look_i(btn_look_i),
    .sw_addr_i(sw_addr_i), .sw_data_i(sw_data_i),
    .core_val_i(core_val_i), .core_wen_i(core_wen_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_rdy_o(core_rdy_o), .core_rdata_o(core_rdata_o),
    .mem_val_o(mem_val_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdy_i(mem_rdy_i), .mem_rdata_i(mem_rdata_i),
    .disp_data_o(disp_data_o), .disp_upd_o(disp_upd_o), .panel_busy_o(panel_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit wen; logic [7:0] addr; logic [15:0] wdata; } tx_t;
  tx_t         txq[$];
  logic [15:0] mem [256];
  logic [15:0] exp_mem [256];
  int wait_cfg = 0, wcnt = 0, vlen = 0, last_len = 0, upd_cnt = 0, crdy_cnt = 0;
  int ncmp = 0, nfail = 0;

  // Memory responder: answers after wait_cfg stall cycles and logs each completed transaction.
  initial forever begin
    @(negedge clk_i);
    if (!rst_ni) begin
      mem_rdy_i = 1'b0; wcnt = 0; vlen = 0;
    end else if (mem_val_o) begin
      vlen++;
      if (wcnt >= wait_cfg) begin
        mem_rdy_i   = 1'b1;
        mem_rdata_i = mem_wen_o ? 16'h0 : mem[mem_addr_o];
        txq.push_back('{wen: mem_wen_o, addr: mem_addr_o, wdata: mem_wdata_o});
        if (mem_wen_o) mem[mem_addr_o] = mem_wdata_o;
        last_len = vlen; vlen = 0; wcnt = 0;
      end else begin
        mem_rdy_i = 1'b0; wcnt++;
      end
    end else begin
      mem_rdy_i = 1'b0; wcnt = 0; vlen = 0;
    end
    #1;
    if (disp_upd_o) upd_cnt++;
    if (core_rdy_o) crdy_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #2;
  endtask

  function automatic logic [7:0] model_addr(input logic [7:0] sw);
`ifdef PANEL_AUTOINC_EN
    logic [7:0] used;
    used = (sw != m_sa) ? sw : m_pa;
    m_sa = sw;
    m_pa = used + 8'd1;
    return used;
`else
    return sw;
`endif
  endfunction

  task automatic model_reset();
`ifdef PANEL_AUTOINC_EN
    m_pa = '0; m_sa = '0;
`endif
  endtask

  task automatic press(input bit ld, input bit lk);
    btn_load_i = ld; btn_look_i = lk;
    tick();
    btn_load_i = 1'b0; btn_look_i = 1'b0;
    tick();
  endtask

  task automatic wait_upd(input string tag, input int u0);
    int n = 0;
    while (upd_cnt == u0 && n < 60) begin tick(); n++; end
    chk({tag, "_done_in_time"}, n < 60, 1);
  endtask

  task automatic finish_panel(input string tag, input bit ld, input logic [7:0] used,
                              input logic [15:0] d, input int idx, input int u0);
    logic [15:0] exp_disp;
    wait_upd(tag, u0);
    exp_disp = ld ? d : exp_mem[used];
    if (ld) exp_mem[used] = d;
    chk({tag, "_ntx"}, txq.size(), idx + 1);
    if (txq.size() > idx) begin
      chk({tag, "_wen"}, txq[idx].wen, ld);
      chk({tag, "_addr"}, txq[idx].addr, used);
      if (ld) chk({tag, "_wdata"}, txq[idx].wdata, d);
    end
    chk({tag, "_disp"}, disp_data_o, exp_disp);
    tick(); tick();
    chk({tag, "_upd_once"}, upd_cnt, u0 + 1);
    chk({tag, "_busy_clr"}, panel_busy_o, 0);
  endtask

  task automatic panel_op(input string tag, input bit ld, input bit lk, input logic [7:0] a,
                          input logic [15:0] d, input int wt);
    int n0 = txq.size();
    int u0 = upd_cnt;
    logic [7:0] used;
    sw_addr_i = a; sw_data_i = d; wait_cfg = wt;
    used = model_addr(a);
    press(ld, lk);
    finish_panel(tag, ld, used, d, n0, u0);
  endtask

  task automatic core_op(input string tag, input bit wen, input logic [7:0] a, input logic [15:0] d);
    int n = 0;
    int c0 = crdy_cnt;
    logic [15:0] exp_r = exp_mem[a];
    core_val_i = 1'b1; core_wen_i = wen; core_addr_i = a; core_wdata_i = d;
    while (!core_rdy_o && n < 60) begin tick(); n++; end
    chk({tag, "_rdy_in_time"}, n < 60, 1);
    if (!wen) chk({tag, "_rdata"}, core_rdata_o, exp_r);
    @(posedge clk_i);
    #1;
    core_val_i = 1'b0;
    if (wen) exp_mem[a] = d;
    tick();
    chk({tag, "_rdy_once"}, crdy_cnt, c0 + 1);
  endtask

  initial begin
    int n0, u0, n;
    logic [7:0]  a, used;
    logic [15:0] d, v;
    logic [7:0]  ai_exp [3];

    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      mem[i] = v; exp_mem[i] = v;
    end

    // Reset state
    rst_ni = 1'b0;
    tick(); tick();
    chk("rst_mem_val", mem_val_o, 0);
    chk("rst_mem_wen", mem_wen_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_core_rdy", core_rdy_o, 0);
    chk("rst_disp", disp_data_o, 0);
    chk("rst_upd", disp_upd_o, 0);
    chk("rst_busy", panel_busy_o, 0);
    rst_ni = 1'b1;
    panel_en_i = 1'b1;
    tick();

    // LOAD with zero-wait memory, then LOOK with three stall cycles
    panel_op("s1_load", 1, 0, 8'h10, 16'hBEEF, 0);
    panel_op("s2_look", 0, 1, 8'h10, 16'h1234, 3);
    chk("s2_val_len", last_len, 4);

    // Core read and LOOK edge in the same IDLE cycle: core first
    n0 = txq.size(); u0 = upd_cnt;
    a = 8'($urandom); d = 16'($urandom);
    sw_addr_i = a; sw_data_i = d; wait_cfg = 2;
    used = model_addr(a);
    btn_look_i = 1'b1;
    core_op("s3_core", 0, 8'h20, 16'h0);
    btn_look_i = 1'b0;
    if (txq.size() > n0) begin
      chk("s3_first_addr", txq[n0].addr, 8'h20);
      chk("s3_first_wen", txq[n0].wen, 0);
    end
    finish_panel("s3_look", 0, used, d, n0 + 1, u0);

    // LOOK while panel disabled stays pending until panel_en_i rises
    panel_en_i = 1'b0;
    n0 = txq.size(); u0 = upd_cnt;
    a = 8'($urandom); d = 16'($urandom);
    sw_addr_i = a; sw_data_i = d; wait_cfg = 0;
    used = model_addr(a);
    press(0, 1);
    repeat (5) tick();
    chk("s4_no_tx", txq.size(), n0);
    chk("s4_busy", panel_busy_o, 1);
    panel_en_i = 1'b1;
    n = 0;
    while (!mem_val_o && n < 10) begin tick(); n++; end
    chk("s4_issue_latency", n <= 2, 1);
    finish_panel("s4_look", 0, used, d, n0, u0);

    // Simultaneous LOAD and LOOK: one write only
    panel_op("s5_both", 1, 1, 8'($urandom), 16'($urandom), 1);

    // Reset in the middle of a stalled panel read
    sw_addr_i = 8'($urandom); wait_cfg = 6;
    used = model_addr(sw_addr_i);
    press(0, 1);
    n = 0;
    while (!mem_val_o && n < 10) begin tick(); n++; end
    chk("s6_val_before", mem_val_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("s6_val_rst", mem_val_o, 0);
    chk("s6_disp_rst", disp_data_o, 0);
    chk("s6_busy_rst", panel_busy_o, 0);
    tick(); tick();
    rst_ni = 1'b1;
    model_reset();
    tick();

    // Randomized mix of panel and core traffic
    for (int k = 0; k < 10; k++) begin
      a = 8'($urandom); d = 16'($urandom);
      case ($urandom_range(0, 2))
        0: panel_op("r_load", 1, 0, a, d, int'($urandom_range(0, 3)));
        1: panel_op("r_look", 0, 1, a, d, int'($urandom_range(0, 3)));
        default: begin
          wait_cfg = int'($urandom_range(0, 3));
          core_op("r_core_wr", 1, a, d);
          core_op("r_core_rd", 0, a, 16'h0);
        end
      endcase
    end

`ifdef PANEL_AUTOINC_EN
    rst_ni = 1'b0; tick(); rst_ni = 1'b1; model_reset(); tick();
    ai_exp[0] = 8'hFE; ai_exp[1] = 8'hFF; ai_exp[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      panel_op("ai_look", 0, 1, 8'hFE, 16'h0, 0);
      chk("ai_addr", txq[txq.size() - 1].addr, ai_exp[k]);
      chk("ai_pa", panel_addr_o, ai_exp[k] + 8'd1);
    end
    panel_op("ai_new_sw", 0, 1, 8'h05, 16'h0, 0);
    chk("ai_addr_sw", txq[txq.size() - 1].addr, 8'h05);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
